edge_detect: RTL and testbench
==============================

Name: edge_detect

Overview:
- Per-bit edge detector on an asynchronous or slow level input vector, e.g. delay-line taps and trigger inputs.
- Resynchronises each input bit into the clk domain and emits single-cycle pulses on rising, falling, or selected edges.
- Keeps a saturating count of cycles in which any selected edge occurred.
- Sits between raw input pins or taps and downstream single-clock control logic.

Parameters:
- WIDTH, 1, number of independent input bits (≥1).
- SYNC_STAGES, 2, synchroniser flops per bit before detection (0 = input already synchronous; allowed range 0..4).
- EDGE_MODE, 2, which edges drive out: 0 = rising, 1 = falling, 2 = both.
- RESET_LEVEL, 0, level loaded into every synchroniser flop and history flop on reset (applies to all bits).
- COUNT_WIDTH, 16, width of the edge event counter (≥1).

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  WIDTH  level inputs; need not be synchronous to clk when SYNC_STAGES≥1.
- clr  input  1  synchronous clear of count, active high.
- out  output  WIDTH  per-bit pulse on the edge type chosen by EDGE_MODE.
- rise  output  WIDTH  per-bit rising-edge pulse, independent of EDGE_MODE.
- fall  output  WIDTH  per-bit falling-edge pulse, independent of EDGE_MODE.
- count  output  COUNT_WIDTH  number of cycles in which out was nonzero; saturating.

Behaviour:
- Reset (async assert, take effect immediately):
  - All synchroniser flops and per-bit history flop prev load RESET_LEVEL.
  - out, rise and fall go to 0; count goes to 0.
- Release of rst is sampled on clk; first normal update occurs at the first rising clk edge with rst low.
- Pipeline per bit:
  - s = output of SYNC_STAGES-deep flop chain; with SYNC_STAGES=0, s = in directly.
  - Each clk edge: prev <= s; rise <= s & ~prev; fall <= ~s & prev; out <= the mode-selected rise/fall/either term, computed from the same s and prev.
- All outputs are registered; no combinational path from in to any output.
- Latency: an input change present at clk edge k appears at s after SYNC_STAGES edges. The pulse is then high for exactly one clock period starting at edge k+SYNC_STAGES.
  - With defaults, an input that changes between edges k-1 and k produces a pulse that is high from edge k+2 to edge k+3.
- Pulse width is always exactly 1 cycle per edge.
- An input toggling every cycle, after synchronisation, produces back-to-back pulses: rise and fall alternate, and out stays high continuously in mode 2.
- Glitches shorter than one clock period that are not captured by the first flop produce no pulse.
- Bits are fully independent; simultaneous edges on several bits pulse in the same cycle.
- Counter:
  - On each clk edge where the newly computed out value is nonzero, count increments by 1.
  - Holds at all-ones (saturates) rather than wrapping.
  - clr has priority over increment: count <= 0 on that edge, and an edge in the same cycle is not counted.
- Reset level edge case: if in differs from RESET_LEVEL when reset is released, an edge pulse is produced once the value propagates. This is intentional.
- Reset mid-operation aborts any in-flight pulse immediately; no pulse is owed after release except per the rule above.
- Illegal EDGE_MODE values (3) behave as mode 2.

Test Plan:
- Defaults, in=0 after reset, toggle in every 2 cycles for 50 toggles -> 25 rise and 25 fall pulses; each pulse is 1 cycle wide and lags the toggle by 2 cycles; count=50 at the end.
- SYNC_STAGES=0, EDGE_MODE=0, in 0→1 just before edge k -> rise=1 and out=1 for cycle k only; fall stays 0; count increments to 1.
- EDGE_MODE=1, WIDTH=4, in 4'h0→4'hF→4'h5 -> first step: rise=4'hF and out=0; second step: fall=4'hA and out=4'hA; count=1.
- Hold in=1 through reset, RESET_LEVEL=0 -> one rise pulse SYNC_STAGES+1 edges after release, then quiet; with RESET_LEVEL=1 -> no pulse.
- COUNT_WIDTH=3, generate 10 edges -> count saturates at 7; pulse clr together with an edge -> count=0.
- Assert rst asynchronously (mid-cycle) while a pulse is high -> out, rise, fall and count drop to 0 before the next clk edge.

Source files
------------

// File: rtl/edge_detect.sv
// ----------------------------------------------------------------------------
// edge_detect
//   Per-bit edge detector for asynchronous or slow level inputs. Each bit is
//   resynchronised into the clk domain, then compared with its previous
//   synchronised value to produce registered single-cycle pulses. A saturating
//   counter records how many cycles had at least one selected edge.
//
// Ports:
//   clk    - system clock, all logic on the rising edge
//   rst    - asynchronous active-high reset
//   in     - level inputs (may be asynchronous when SYNC_STAGES >= 1)
//   clr    - synchronous clear of count, wins over increment
//   out    - per-bit pulse on the edge type selected by EDGE_MODE
//   rise   - per-bit rising-edge pulse
//   fall   - per-bit falling-edge pulse
//   count  - saturating number of cycles in which out was nonzero
//
// Parameters:
//   WIDTH        number of independent input bits (>= 1)
//   SYNC_STAGES  synchroniser depth, 0 means in is already synchronous (0..4)
//   EDGE_MODE    0 = rising, 1 = falling, 2 (or 3) = both
//   RESET_LEVEL  level loaded into synchroniser and history flops on reset
//   COUNT_WIDTH  width of the event counter (>= 1)
// ----------------------------------------------------------------------------
module edge_detect #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 2,
  parameter logic        RESET_LEVEL = 1'b0,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in,
  input  logic                   clr,
  output logic [WIDTH-1:0]       out,
  output logic [WIDTH-1:0]       rise,
  output logic [WIDTH-1:0]       fall,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0]       RST_VEC   = {WIDTH{RESET_LEVEL}};
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  // Synchronised view of in
  logic [WIDTH-1:0] s;

  // Synchroniser chain; bypassed entirely when the input is already synchronous
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = in;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= RST_VEC;
          end
        end else begin
          sync_q[0] <= in;
          for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // History of s from the previous cycle
  logic [WIDTH-1:0] prev;

  // Edge terms for the coming clock edge
  logic [WIDTH-1:0] rise_c;
  logic [WIDTH-1:0] fall_c;
  logic [WIDTH-1:0] out_c;

  // Edge classification; unknown mode values fall back to both edges
  always_comb begin
    rise_c = s & ~prev;
    fall_c = ~s & prev;
    case (EDGE_MODE)
      0:       out_c = rise_c;
      1:       out_c = fall_c;
      default: out_c = rise_c | fall_c;
    endcase
  end

  // History and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= RST_VEC;
      rise <= '0;
      fall <= '0;
      out  <= '0;
    end else begin
      prev <= s;
      rise <= rise_c;
      fall <= fall_c;
      out  <= out_c;
    end
  end

  // Saturating event counter; clear wins over a same-cycle edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if ((|out_c) && (count != COUNT_MAX)) begin
      count <= count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_edge_detect.sv
// ----------------------------------------------------------------------------
// tb_edge_detect
//   Four edge_detect instances with different parameter sets share one random
//   8-bit stimulus bus. A reference model keeps the history of sampled input
//   values and derives every expected pulse and count from that history.
// ----------------------------------------------------------------------------
module tb_edge_detect;

  logic       clk;
  logic       rst;
  logic       clr;
  logic [7:0] in;

  // u_a: defaults (WIDTH 1, 2 sync stages, both edges, reset level 0)
  logic        a_out, a_rise, a_fall;
  logic [15:0] a_cnt;
  // u_b: WIDTH 4, no synchroniser, falling edges, 3-bit counter
  logic [3:0]  b_out, b_rise, b_fall;
  logic [2:0]  b_cnt;
  // u_c: WIDTH 4 on in[7:4], 2 sync stages, rising edges, reset level 1
  logic [3:0]  c_out, c_rise, c_fall;
  logic [15:0] c_cnt;
  // u_d: WIDTH 3, 1 sync stage, illegal mode 3, 4-bit counter
  logic [2:0]  d_out, d_rise, d_fall;
  logic [3:0]  d_cnt;

  edge_detect u_a (
    .clk(clk), .rst(rst), .in(in[0]), .clr(clr),
    .out(a_out), .rise(a_rise), .fall(a_fall), .count(a_cnt)
  );

  edge_detect #(
    .WIDTH(4), .SYNC_STAGES(0), .EDGE_MODE(1), .RESET_LEVEL(1'b0), .COUNT_WIDTH(3)
  ) u_b (
    .clk(clk), .rst(rst), .in(in[3:0]), .clr(clr),
    .out(b_out), .rise(b_rise), .fall(b_fall), .count(b_cnt)
  );

  edge_detect #(
    .WIDTH(4), .SYNC_STAGES(2), .EDGE_MODE(0), .RESET_LEVEL(1'b1), .COUNT_WIDTH(16)
  ) u_c (
    .clk(clk), .rst(rst), .in(in[7:4]), .clr(clr),
    .out(c_out), .rise(c_rise), .fall(c_fall), .count(c_cnt)
  );

  edge_detect #(
    .WIDTH(3), .SYNC_STAGES(1), .EDGE_MODE(3), .RESET_LEVEL(1'b0), .COUNT_WIDTH(4)
  ) u_d (
    .clk(clk), .rst(rst), .in(in[2:0]), .clr(clr),
    .out(d_out), .rise(d_rise), .fall(d_fall), .count(d_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs gathered per instance index
  logic [7:0]  obs_r [4];
  logic [7:0]  obs_f [4];
  logic [7:0]  obs_o [4];
  logic [15:0] obs_c [4];

  always_comb begin
    obs_r[0] = 8'(a_rise); obs_f[0] = 8'(a_fall); obs_o[0] = 8'(a_out); obs_c[0] = 16'(a_cnt);
    obs_r[1] = 8'(b_rise); obs_f[1] = 8'(b_fall); obs_o[1] = 8'(b_out); obs_c[1] = 16'(b_cnt);
    obs_r[2] = 8'(c_rise); obs_f[2] = 8'(c_fall); obs_o[2] = 8'(c_out); obs_c[2] = 16'(c_cnt);
    obs_r[3] = 8'(d_rise); obs_f[3] = 8'(d_fall); obs_o[3] = 8'(d_out); obs_c[3] = 16'(d_cnt);
  end

  // Instance parameters as seen by the model
  function automatic int p_st(input int i);
    case (i) 0: return 2; 1: return 0; 2: return 2; default: return 1; endcase
  endfunction
  function automatic int p_w(input int i);
    case (i) 0: return 1; 1: return 4; 2: return 4; default: return 3; endcase
  endfunction
  function automatic int p_mode(input int i);
    case (i) 0: return 2; 1: return 1; 2: return 0; default: return 3; endcase
  endfunction
  function automatic bit p_rl(input int i);
    return (i == 2);
  endfunction
  function automatic int p_lo(input int i);
    return (i == 2) ? 4 : 0;
  endfunction
  function automatic int p_cw(input int i);
    case (i) 0: return 16; 1: return 3; 2: return 16; default: return 4; endcase
  endfunction

  // Reference model state: hist[n] is the input present at the n-th edge
  // after reset release (hist[0] is an unused filler entry).
  logic [7:0] hist [$];
  logic [7:0] er [4];
  logic [7:0] ef [4];
  logic [7:0] eo [4];
  int         ec [4];

  int n_pass;
  int n_total;

  function automatic logic [7:0] lane_mask(input int i);
    return 8'((1 << p_w(i)) - 1);
  endfunction

  // Synchronised value of an instance as of edge idx; before release it is
  // the reset level.
  function automatic logic [7:0] hval(input int i, input int idx);
    if (idx < 1) return p_rl(i) ? lane_mask(i) : 8'h00;
    return (hist[idx] >> p_lo(i)) & lane_mask(i);
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(8'h00);
    for (int i = 0; i < 4; i++) begin
      er[i] = 8'h00; ef[i] = 8'h00; eo[i] = 8'h00; ec[i] = 0;
    end
  endtask

  // The edge at which input value is sampled; an edge shows up once the
  // value has travelled through the instance's synchroniser depth.
  task automatic model_edge();
    int n;
    logic [7:0] sv, pv, r, f, o;
    hist.push_back(in);
    n = hist.size() - 1;
    for (int i = 0; i < 4; i++) begin
      sv = hval(i, n - p_st(i));
      pv = hval(i, n - 1 - p_st(i));
      r  = sv & ~pv;
      f  = ~sv & pv;
      if (p_mode(i) == 0)      o = r;
      else if (p_mode(i) == 1) o = f;
      else                     o = r | f;
      er[i] = r; ef[i] = f; eo[i] = o;
      if (clr) ec[i] = 0;
      else if (o != 8'h00 && ec[i] < (1 << p_cw(i)) - 1) ec[i] = ec[i] + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d.rise", i), 16'(obs_r[i]), 16'(er[i]));
      chk($sformatf("u%0d.fall", i), 16'(obs_f[i]), 16'(ef[i]));
      chk($sformatf("u%0d.out", i),  16'(obs_o[i]), 16'(eo[i]));
      chk($sformatf("u%0d.count", i), obs_c[i], 16'(ec[i]));
    end
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check 1 later
  task automatic cyc(input logic [7:0] v, input logic c, input logic r);
    @(negedge clk);
    in  = v;
    clr = c;
    rst = r;
    if (r) model_reset();
    @(posedge clk);
    if (!rst) model_edge();
    #1 check_all();
  endtask

  // One clock with a short glitch well clear of the sampling edge
  task automatic cyc_glitch(input logic [7:0] gmask);
    logic [7:0] hold;
    @(negedge clk);
    hold = in;
    clr  = 1'b0;
    in   = hold ^ gmask;
    #2 in = hold;
    @(posedge clk);
    if (!rst) model_edge();
    #1 check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic t;
    logic [7:0] v;
    n_pass  = 0;
    n_total = 0;
    in  = 8'h00;
    clr = 1'b0;
    rst = 1'b1;
    model_reset();

    // Reset state
    repeat (3) cyc(8'h00, 1'b0, 1'b1);

    // Bit 0 toggles every 2 cycles for 50 toggles; upper bits random
    t = 1'b0;
    for (int k = 0; k < 104; k++) begin
      if (k < 100 && (k % 2) == 0) t = ~t;
      cyc({7'($urandom), t}, 1'b0, 1'b0);
    end
    chk("a.count_after_50_toggles", obs_c[0], 16'd50);

    // Falling-edge mode on a nibble: 0 -> F -> 5
    cyc(8'h00, 1'b1, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h0F, 1'b0, 1'b0);
    chk("b.step1_rise", 16'(obs_r[1]), 16'h000F);
    chk("b.step1_out",  16'(obs_o[1]), 16'h0000);
    cyc(8'h05, 1'b0, 1'b0);
    chk("b.step2_fall", 16'(obs_f[1]), 16'h000A);
    chk("b.step2_out",  16'(obs_o[1]), 16'h000A);
    chk("b.step2_count", obs_c[1], 16'd1);

    // Random traffic with occasional clears and sub-cycle glitches
    for (int k = 0; k < 200; k++) begin
      v = 8'($urandom);
      if ($urandom_range(0, 7) == 0) cyc_glitch(8'($urandom));
      else cyc(v, ($urandom_range(0, 15) == 0), 1'b0);
    end

    // Saturation of the 3-bit counter, then clear alongside an edge
    cyc(8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) cyc(((k % 2) == 0) ? 8'h0F : 8'h00, 1'b0, 1'b0);
    chk("b.count_saturated", obs_c[1], 16'd7);
    cyc(8'h0F, 1'b0, 1'b0);
    cyc(8'h00, 1'b1, 1'b0);
    chk("b.clr_with_edge_fall", 16'(obs_f[1]), 16'h000F);
    chk("b.clr_with_edge_count", obs_c[1], 16'd0);

    // Input held high through reset
    repeat (3) cyc(8'hFF, 1'b0, 1'b1);
    cyc(8'hFF, 1'b0, 1'b0);
    cyc(8'hFF, 1'b0, 1'b0);
    chk("a.no_rise_before_sync", 16'(obs_r[0]), 16'h0000);
    cyc(8'hFF, 1'b0, 1'b0);
    chk("a.release_rise", 16'(obs_r[0]), 16'h0001);
    chk("c.release_level1_quiet", 16'(obs_r[2]), 16'h0000);
    cyc(8'hFF, 1'b0, 1'b0);
    chk("a.release_rise_once", 16'(obs_r[0]), 16'h0000);
    repeat (2) cyc(8'hFF, 1'b0, 1'b0);

    // Asynchronous reset while a pulse is high
    repeat (3) cyc(8'h00, 1'b0, 1'b0);
    chk("a.pulse_before_async_rst", 16'(obs_o[0]), 16'h0001);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("a.out_async_rst", 16'(obs_o[0]), 16'h0000);
    check_all();
    repeat (2) cyc(8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 30; k++) cyc(8'($urandom), 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
